muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the EX stage. Accepts one MULT/MULTU/DIV/DIVU request, runs a shared radix-2 shift-add/shift-subtract datapath for 32 cycles, and writes the 64-bit result into the architectural HI/LO registers. It also services MTHI/MTLO writes and generates the stall that holds the pipeline while HI/LO is not yet valid.

---
 rtl/muldiv_seq_if.sv | 28 ++
 rtl/muldiv_seq.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the EX stage and the
// iterative multiply/divide sequencer, including the HI/LO register view.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hilo_rd;
    logic [1:0]       hilo_we;
    logic [WIDTH-1:0] hilo_wdata;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, hilo_rd, hilo_we, hilo_wdata,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, hilo_rd, hilo_we, hilo_wdata,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Define MULDIV_DIV_EN to build the restoring-divide datapath; without it,
// divide ops take the divide-by-zero path (HI/LO untouched, done after FIX).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | one radix-2 iteration per cycle, WIDTH cycles
// FIX   | sign fix-up, HI/LO written (skipped for divide-by-zero)
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_res_q, neg_res_d;
    logic               skip_q, skip_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               busy;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_fix;

`ifdef MULDIV_DIV_EN
    logic               is_div_q, is_div_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
`endif

    assign busy      = (state_q != IDLE);
    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.stall = busy & (bus.hilo_rd | (bus.hilo_we != 2'b00) | bus.start);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    // Operand magnitudes and single-iteration datapath steps
    always_comb begin
        rs_neg   = bus.op[0] & bus.rs_val[WIDTH-1];
        rt_neg   = bus.op[0] & bus.rt_val[WIDTH-1];
        rs_mag   = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_mag   = rt_neg ? -bus.rt_val : bus.rt_val;
        // shift-add: upper half accumulates multiplicand, whole pair shifts right
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        mul_fix  = neg_res_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
        // restoring step: remainder in upper half, quotient shifts in at bit 0
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opa_q});
        div_rem   = div_shift[WIDTH-1:0] - opa_q;
        div_next  = {(div_ge ? div_rem : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
`endif
    end

    // Next-state, datapath and HI/LO update
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        opa_d     = opa_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        skip_d    = skip_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
`endif

        // MTHI/MTLO only while idle; a same-cycle start overwrites later in FIX
        if (!busy) begin
            if (bus.hilo_we[1]) hi_d = bus.hilo_wdata;
            if (bus.hilo_we[0]) lo_d = bus.hilo_wdata;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    neg_res_d = rs_neg ^ rt_neg;
                    count_d   = '0;
                    skip_d    = 1'b0;
`ifdef MULDIV_DIV_EN
                    is_div_d  = bus.op[1];
                    neg_rem_d = rs_neg;
                    if (bus.op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, rs_mag};
                        opa_d = rt_mag;
                        if (bus.rt_val == '0) begin
                            skip_d  = 1'b1;
                            state_d = FIX;
                        end else begin
                            state_d = CALC;
                        end
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, rt_mag};
                        opa_d   = rs_mag;
                        state_d = CALC;
                    end
`else
                    if (bus.op[1]) begin
                        skip_d  = 1'b1;
                        state_d = FIX;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, rt_mag};
                        opa_d   = rs_mag;
                        state_d = CALC;
                    end
`endif
                end
            end
            CALC: begin
                count_d = count_q + CW'(1);
`ifdef MULDIV_DIV_EN
                acc_d   = is_div_q ? div_next : mul_next;
`else
                acc_d   = mul_next;
`endif
                if (count_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!skip_q) begin
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end else begin
                        hi_d = mul_fix[2*WIDTH-1:WIDTH];
                        lo_d = mul_fix[WIDTH-1:0];
                    end
`else
                    hi_d = mul_fix[2*WIDTH-1:WIDTH];
                    lo_d = mul_fix[WIDTH-1:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset discards in-flight op
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            opa_q     <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            skip_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            opa_q     <= opa_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            skip_q    <= skip_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq; expectations follow the
// MULDIV_DIV_EN build setting.
module tb_muldiv_seq;
    localparam int W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(W)) bus ();
    muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] exp_hi, exp_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait (bounded) for done and check latency and HI/LO.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit upd,
                          input logic [31:0] rhi, input logic [31:0] rlo);
        int lat;
        bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (upd) begin
            exp_hi = rhi;
            exp_lo = rlo;
        end
        chk({tag, "_lat"}, 64'(lat), upd ? 64'd34 : 64'd2);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        tick();
        chk({tag, "_done_w"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
        bus.hilo_rd = 1'b0; bus.hilo_we = 2'b00; bus.hilo_wdata = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);

        // MULT -3 * 7 with MFHI pending throughout
        bus.hilo_rd = 1'b1;
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'hFFFF_FFFD; bus.rt_val = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            chk("mult_busy", 64'(bus.busy), 64'd1);
            chk("mult_stall", 64'(bus.stall), 64'd1);
            chk("mult_done_early", 64'(bus.done), 64'd0);
            tick();
        end
        chk("mult_done", 64'(bus.done), 64'd1);
        chk("mult_busy_end", 64'(bus.busy), 64'd0);
        chk("mult_stall_end", 64'(bus.stall), 64'd0);
        chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);
        bus.hilo_rd = 1'b0;
        tick();
        chk("mult_done_w", 64'(bus.done), 64'd0);

        // MTHI / MTLO preload
        bus.hilo_we = 2'b10; bus.hilo_wdata = 32'h11;
        tick();
        chk("mthi_hi", 64'(bus.hi), 64'h11);
        chk("mthi_lo", 64'(bus.lo), 64'hFFFF_FFEB);
        bus.hilo_we = 2'b01; bus.hilo_wdata = 32'h22;
        tick();
        bus.hilo_we = 2'b00;
        chk("mtlo_lo", 64'(bus.lo), 64'h22);
        chk("mtlo_done", 64'(bus.done), 64'd0);
        exp_hi = 32'h11; exp_lo = 32'h22;

        // divide by zero, then signed/unsigned divides
        run_op("div0", 2'b11, 32'd5, 32'd0, 1'b0, 32'h0, 32'h0);
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, DIV_EN, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, DIV_EN, 32'd1, 32'hFFFF_FFFD);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, DIV_EN, 32'd2, 32'd14);
        run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN, 32'h0, 32'h8000_0000);
        run_op("mult_m3_m5", 2'b01, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 32'h0, 32'd15);
        run_op("mult_min2", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0);

        // same-cycle start + MTHI/MTLO, then ignored write and start while busy
        bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
        bus.hilo_we = 2'b11; bus.hilo_wdata = 32'hAB;
        tick();
        bus.start = 1'b0; bus.hilo_we = 2'b00;
        chk("same_hi", 64'(bus.hi), 64'hAB);
        chk("same_lo", 64'(bus.lo), 64'hAB);
        chk("same_busy", 64'(bus.busy), 64'd1);
        tick(); tick();
        bus.hilo_we = 2'b01; bus.hilo_wdata = 32'hCD;
        #1;
        chk("we_busy_stall", 64'(bus.stall), 64'd1);
        tick();
        bus.hilo_we = 2'b00;
        chk("we_busy_ignored", 64'(bus.lo), 64'hAB);
        tick();
        bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd2; bus.rt_val = 32'd3;
        #1;
        chk("start_busy_stall", 64'(bus.stall), 64'd1);
        tick();
        bus.start = 1'b0;
        lat = 6;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("multu_3_5_lat", 64'(lat), 64'd34);
        chk("multu_3_5_hi", 64'(bus.hi), 64'h0);
        chk("multu_3_5_lo", 64'(bus.lo), 64'd15);
        tick();
        chk("second_not_started", 64'(bus.busy), 64'd0);
        chk("second_no_done", 64'(bus.done), 64'd0);

        // reset in the middle of a MULTU
        bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'hFFFF_FFFF; bus.rt_val = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        reset = 1'b1;
        tick();
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_hi", 64'(bus.hi), 64'd0);
        chk("midrst_lo", 64'(bus.lo), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        exp_hi = 32'h0; exp_lo = 32'h0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.done === 1'b1) seen++;
        end
        chk("midrst_no_done", 64'(seen), 64'd0);
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
